alarm_clock_core: RTL and testbench
===================================

// Module: alarm_clock_core
// PURPOSE
//  Time-of-day counter (hr:min:sec) advanced by a 1 Hz tick enable, loadable at run time,
//  with NUM_ALARMS independently programmable alarm channels, each running a ring state machine.
//  It replaces the free-running digital_clock counter.
//  It sits behind the clock divider (tick source) and ahead of the display and buzzer logic.
// PARAMETERS
//  NUM_ALARMS     2    number of alarm channels, 1..8
//  HOURS_PER_DAY  24   hour wrap value; hr counts 0..HOURS_PER_DAY-1, legal range 2..32
//  RING_SECS      60   ticks an alarm rings before it stops by itself, >=1
//  SNOOZE_MIN     5    snooze length in minutes, >=1 (used only with SNOOZE_EN)
// PORTS  (AW = NUM_ALARMS>1 ? $clog2(NUM_ALARMS) : 1)
//  clk        in   1           system clock
//  rst        in   1           synchronous reset, active-high
//  tick       in   1           one-cycle pulse, one per second
//  set_valid  in   1           load time from set_hr/set_min/set_sec
//  set_hr     in   5           load hour
//  set_min    in   6           load minute
//  set_sec    in   6           load second
//  alm_wr     in   1           write alarm channel alm_sel
//  alm_sel    in   AW          alarm channel index
//  alm_hr     in   5           alarm hour
//  alm_min    in   6           alarm minute
//  alm_arm    in   1           1 = channel armed, 0 = disarmed
//  ack        in   NUM_ALARMS  per-channel dismiss
//  snooze     in   NUM_ALARMS  per-channel snooze request
//  hr         out  5           current hour
//  min        out  6           current minute
//  sec        out  6           current second
//  ringing    out  NUM_ALARMS  channel i is in RINGING
//  rollover   out  1           one-cycle pulse on the day wrap
//  set_err    out  1           one-cycle pulse when a load or alarm write is rejected
// BEHAVIOUR
//  Reset (rst at posedge clk): hr/min/sec=0, all channels IDLE and disarmed, alarm regs=0,
//   ringing=0, rollover=0, set_err=0.
//  Time update on each tick: sec+1. At 59, sec goes to 0 and min+1.
//   At 59:59, min goes to 0 and hr+1.
//   At HOURS_PER_DAY-1:59:59, all fields go to 0 and rollover=1 for that cycle.
//  Load: set_valid with set_hr<HOURS_PER_DAY, set_min<=59, set_sec<=59 loads the time on the next edge.
//   If any field is out of range, the time is unchanged and set_err=1 for one cycle.
//   set_valid beats tick in the same cycle; that tick is dropped.
//  Alarm write: alm_wr stores alm_hr/alm_min/alm_arm into channel alm_sel and forces it to IDLE.
//   It is rejected (no write, set_err=1) if alm_sel>=NUM_ALARMS or any field is out of range.
//  Trigger: an armed IDLE channel enters RINGING on the same edge that a tick moves the time to
//   alm_hr:alm_min:00. ringing[i] and the new time registers update together (0-cycle latency).
//   A load that lands on the alarm time does not trigger it.
//  Per-channel FSM (IDLE, RINGING, SNOOZED):
//   IDLE->RINGING   on trigger; ring counter cleared.
//   RINGING->IDLE   on ack[i], or once RING_SECS ticks are counted in RINGING.
//   RINGING->SNOOZED  on snooze[i] (SNOOZE_EN only); snooze counter cleared.
//   SNOOZED->RINGING  after SNOOZE_MIN*60 ticks; ring counter cleared.
//   SNOOZED->IDLE   on ack[i].
//   ack beats snooze, and ack beats a trigger in the same cycle.
//   Disarming a channel (alm_wr with alm_arm=0) forces it to IDLE at once.
//  Every channel is evaluated in parallel, and any number of them may ring at once.
//  All outputs are registered. A reset mid-ring returns every channel to IDLE with no residue.
// CONFIGURATION
//  ALARM_SNOOZE_EN defined: snooze[] is honoured, SNOOZED is reachable, and each channel carries a
//   snooze counter wide enough for SNOOZE_MIN*60.
//  Not defined: the snooze port stays in place but is ignored, SNOOZED and its counter are not
//   built, and ack or the timeout are the only exits from RINGING.
// TESTING
//  1 Reset, then 86400 ticks -> time is back to 00:00:00, exactly one rollover pulse at that tick.
//  2 Load 23:59:58, then 2 ticks -> 23:59:59, then 00:00:00 with rollover=1.
//    Load hr=24 -> set_err=1, time unchanged.
//  3 Alarm0 = 07:30 armed, load 07:29:58, 2 ticks -> ringing[0] rises on the 07:30:00 edge.
//    After 60 more ticks with no ack -> ringing[0]=0.
//  4 Alarm0 and alarm1 both at 06:00, ack[1] 3 ticks after the trigger
//    -> ringing=2'b01, then ringing[0] times out on its own.
//  5 (ALARM_SNOOZE_EN) snooze[0] while ringing -> ringing[0]=0.
//    After 300 ticks -> ringing[0]=1 again. ack[0] -> IDLE.
//  6 set_valid and tick in the same cycle -> loaded value wins.
//    rst asserted during RINGING -> all outputs at reset values on the next edge.

Source files
------------

// File: rtl/alarm_clock_core.sv
// alarm_clock_core: hr:min:sec time-of-day counter advanced by a 1 Hz tick,
// run-time loadable, with NUM_ALARMS independent alarm channels.
// Ports: clk, rst (sync, active-high), tick, set_valid/set_hr/set_min/set_sec,
//   alm_wr/alm_sel/alm_hr/alm_min/alm_arm, ack[], snooze[] ->
//   hr/min/sec, ringing[], rollover, set_err.
// Build option: define ALARM_SNOOZE_EN to honour snooze[] (SNOOZED state).
module alarm_clock_core #(
    parameter int NUM_ALARMS    = 2,
    parameter int HOURS_PER_DAY = 24,
    parameter int RING_SECS     = 60,
    parameter int SNOOZE_MIN    = 5,
    localparam int AW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic                  set_valid,
    input  logic [4:0]            set_hr,
    input  logic [5:0]            set_min,
    input  logic [5:0]            set_sec,
    input  logic                  alm_wr,
    input  logic [AW-1:0]         alm_sel,
    input  logic [4:0]            alm_hr,
    input  logic [5:0]            alm_min,
    input  logic                  alm_arm,
    input  logic [NUM_ALARMS-1:0] ack,
    input  logic [NUM_ALARMS-1:0] snooze,
    output logic [4:0]            hr,
    output logic [5:0]            min,
    output logic [5:0]            sec,
    output logic [NUM_ALARMS-1:0] ringing,
    output logic                  rollover,
    output logic                  set_err
);
    localparam int RW = $clog2(RING_SECS + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RING = 2'd1,
        S_SNZ  = 2'd2
    } st_t;

    logic [4:0] inc_hr;
    logic [5:0] inc_min;
    logic [5:0] inc_sec;
    logic       wrap;
    logic       tick_adv;
    logic       load_ok;
    logic       wr_ok;

    logic [NUM_ALARMS-1:0]        armed;
    logic [NUM_ALARMS-1:0][4:0]   a_hr;
    logic [NUM_ALARMS-1:0][5:0]   a_min;
    logic [NUM_ALARMS-1:0]        wsel;
    logic [NUM_ALARMS-1:0]        hit;

    st_t  [NUM_ALARMS-1:0]        st;
    st_t  [NUM_ALARMS-1:0]        st_n;
    logic [NUM_ALARMS-1:0][RW-1:0] rc;
    logic [NUM_ALARMS-1:0][RW-1:0] rc_n;
    logic [NUM_ALARMS-1:0]        ring_n;

`ifdef ALARM_SNOOZE_EN
    localparam int SNZ = SNOOZE_MIN * 60;
    localparam int SW  = $clog2(SNZ + 1);
    logic [NUM_ALARMS-1:0][SW-1:0] sc;
    logic [NUM_ALARMS-1:0][SW-1:0] sc_n;
`else
    logic unused_snooze;
    assign unused_snooze = ^snooze;
`endif

    // A load in the same cycle swallows the tick.
    assign tick_adv = tick & ~set_valid;

    assign load_ok = (32'(set_hr) < HOURS_PER_DAY) &&
                     (set_min <= 6'd59) && (set_sec <= 6'd59);

    assign wr_ok = (32'(alm_sel) < NUM_ALARMS) &&
                   (32'(alm_hr) < HOURS_PER_DAY) && (alm_min <= 6'd59);

    // Time one tick ahead of the current value.
    always_comb begin
        inc_hr  = hr;
        inc_min = min;
        inc_sec = sec + 6'd1;
        wrap    = 1'b0;
        if (sec == 6'd59) begin
            inc_sec = 6'd0;
            inc_min = min + 6'd1;
            if (min == 6'd59) begin
                inc_min = 6'd0;
                inc_hr  = hr + 5'd1;
                if (hr == 5'(HOURS_PER_DAY - 1)) begin
                    inc_hr = 5'd0;
                    wrap   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hr       <= 5'd0;
            min      <= 6'd0;
            sec      <= 6'd0;
            rollover <= 1'b0;
            set_err  <= 1'b0;
        end else begin
            rollover <= tick_adv & wrap;
            set_err  <= (set_valid & ~load_ok) | (alm_wr & ~wr_ok);
            if (set_valid) begin
                if (load_ok) begin
                    hr  <= set_hr;
                    min <= set_min;
                    sec <= set_sec;
                end
            end else if (tick) begin
                hr  <= inc_hr;
                min <= inc_min;
                sec <= inc_sec;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            armed <= '0;
            a_hr  <= '0;
            a_min <= '0;
        end else begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                if (wsel[i]) begin
                    armed[i] <= alm_arm;
                    a_hr[i]  <= alm_hr;
                    a_min[i] <= alm_min;
                end
            end
        end
    end

    // Trigger only when the tick itself lands on hh:mm:00.
    always_comb begin
        for (int i = 0; i < NUM_ALARMS; i++) begin
            wsel[i] = alm_wr && wr_ok && (alm_sel == AW'(i));
            hit[i]  = tick_adv && armed[i] && (inc_sec == 6'd0) &&
                      (inc_min == a_min[i]) && (inc_hr == a_hr[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st      <= {NUM_ALARMS{S_IDLE}};
            rc      <= '0;
            ringing <= '0;
`ifdef ALARM_SNOOZE_EN
            sc      <= '0;
`endif
        end else begin
            st      <= st_n;
            rc      <= rc_n;
            ringing <= ring_n;
`ifdef ALARM_SNOOZE_EN
            sc      <= sc_n;
`endif
        end
    end

    always_comb begin
        st_n = st;
        rc_n = rc;
`ifdef ALARM_SNOOZE_EN
        sc_n = sc;
`endif
        for (int i = 0; i < NUM_ALARMS; i++) begin
            if (wsel[i]) begin
                st_n[i] = S_IDLE;
            end else begin
                case (st[i])
                    S_IDLE: begin
                        if (hit[i] && !ack[i]) begin
                            st_n[i] = S_RING;
                            rc_n[i] = '0;
                        end
                    end
                    S_RING: begin
                        if (ack[i]) begin
                            st_n[i] = S_IDLE;
`ifdef ALARM_SNOOZE_EN
                        end else if (snooze[i]) begin
                            st_n[i] = S_SNZ;
                            sc_n[i] = '0;
`endif
                        end else if (tick_adv) begin
                            if (rc[i] == RW'(RING_SECS - 1))
                                st_n[i] = S_IDLE;
                            else
                                rc_n[i] = rc[i] + RW'(1);
                        end
                    end
`ifdef ALARM_SNOOZE_EN
                    S_SNZ: begin
                        if (ack[i]) begin
                            st_n[i] = S_IDLE;
                        end else if (tick_adv) begin
                            if (sc[i] == SW'(SNZ - 1)) begin
                                st_n[i] = S_RING;
                                rc_n[i] = '0;
                            end else begin
                                sc_n[i] = sc[i] + SW'(1);
                            end
                        end
                    end
`endif
                    default: st_n[i] = S_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_ALARMS; i++)
            ring_n[i] = (st_n[i] == S_RING);
    end

endmodule

// File: tb/tb_alarm_clock_core.sv
// tb_alarm_clock_core: directed test of alarm_clock_core (default parameters).
// Covers day wrap, loads, rejects, alarm trigger/timeout/ack, reset mid-ring.
module tb_alarm_clock_core;
    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       set_valid;
    logic [4:0] set_hr;
    logic [5:0] set_min;
    logic [5:0] set_sec;
    logic       alm_wr;
    logic [0:0] alm_sel;
    logic [4:0] alm_hr;
    logic [5:0] alm_min;
    logic       alm_arm;
    logic [1:0] ack;
    logic [1:0] snooze;
    logic [4:0] hr;
    logic [5:0] min;
    logic [5:0] sec;
    logic [1:0] ringing;
    logic       rollover;
    logic       set_err;

    int checks = 0;
    int errors = 0;
    int rolls;

    alarm_clock_core dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .set_valid (set_valid),
        .set_hr    (set_hr),
        .set_min   (set_min),
        .set_sec   (set_sec),
        .alm_wr    (alm_wr),
        .alm_sel   (alm_sel),
        .alm_hr    (alm_hr),
        .alm_min   (alm_min),
        .alm_arm   (alm_arm),
        .ack       (ack),
        .snooze    (snooze),
        .hr        (hr),
        .min       (min),
        .sec       (sec),
        .ringing   (ringing),
        .rollover  (rollover),
        .set_err   (set_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] t(int h, int m, int s);
        return {15'd0, 5'(h), 6'(m), 6'(s)};
    endfunction

    function automatic logic [31:0] now();
        return {15'd0, hr, min, sec};
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(int n);
        tick = 1'b1;
        repeat (n) step();
        tick = 1'b0;
    endtask

    task automatic load(int h, int m, int s);
        set_valid = 1'b1;
        set_hr    = 5'(h);
        set_min   = 6'(m);
        set_sec   = 6'(s);
        step();
        set_valid = 1'b0;
    endtask

    task automatic wr_alarm(int sel, int h, int m, logic arm);
        alm_wr  = 1'b1;
        alm_sel = 1'(sel);
        alm_hr  = 5'(h);
        alm_min = 6'(m);
        alm_arm = arm;
        step();
        alm_wr = 1'b0;
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; set_valid = 1'b0;
        set_hr = '0; set_min = '0; set_sec = '0;
        alm_wr = 1'b0; alm_sel = '0; alm_hr = '0; alm_min = '0;
        alm_arm = 1'b0; ack = '0; snooze = '0;
        step();
        step();
        rst = 1'b0;
        chk("reset_time", now(), t(0, 0, 0));
        chk("reset_ring", 32'(ringing), 32'd0);
        chk("reset_roll", 32'(rollover), 32'd0);
        chk("reset_err", 32'(set_err), 32'd0);

        // Full day of ticks
        rolls = 0;
        tick = 1'b1;
        for (int i = 0; i < 86400; i++) begin
            step();
            if (rollover) rolls++;
            if (i == 86399) chk("day_last_roll", 32'(rollover), 32'd1);
        end
        tick = 1'b0;
        chk("day_time", now(), t(0, 0, 0));
        chk("day_rolls", 32'(rolls), 32'd1);

        // Load near midnight
        load(23, 59, 58);
        chk("load_time", now(), t(23, 59, 58));
        ticks(1);
        chk("tick_5959", now(), t(23, 59, 59));
        chk("tick_5959_roll", 32'(rollover), 32'd0);
        ticks(1);
        chk("wrap_time", now(), t(0, 0, 0));
        chk("wrap_roll", 32'(rollover), 32'd1);
        step();
        chk("roll_pulse", 32'(rollover), 32'd0);
        load(24, 10, 0);
        chk("bad_hr_err", 32'(set_err), 32'd1);
        chk("bad_hr_time", now(), t(0, 0, 0));
        step();
        chk("err_pulse", 32'(set_err), 32'd0);
        wr_alarm(0, 7, 60, 1'b1);
        chk("bad_alm_err", 32'(set_err), 32'd1);

        // Alarm trigger and timeout
        wr_alarm(0, 7, 30, 1'b1);
        chk("alm_wr_ok", 32'(set_err), 32'd0);
        load(7, 29, 58);
        ticks(1);
        chk("pre_trig", 32'(ringing), 32'd0);
        ticks(1);
        chk("trig_time", now(), t(7, 30, 0));
        chk("trig_ring", 32'(ringing), 32'b01);
        ticks(59);
        chk("ring_59", 32'(ringing), 32'b01);
        ticks(1);
        chk("ring_timeout", 32'(ringing), 32'b00);

        // Load on alarm time does not trigger
        load(7, 30, 0);
        chk("load_no_trig", 32'(ringing), 32'b00);

        // Two channels, ack on one
        wr_alarm(0, 6, 0, 1'b1);
        wr_alarm(1, 6, 0, 1'b1);
        load(5, 59, 59);
        ticks(1);
        chk("dual_trig", 32'(ringing), 32'b11);
        ticks(3);
        chk("dual_3", 32'(ringing), 32'b11);
        ack = 2'b10;
        step();
        ack = 2'b00;
        chk("ack1", 32'(ringing), 32'b01);
        ticks(56);
        chk("ch0_56", 32'(ringing), 32'b01);
        ticks(1);
        chk("ch0_timeout", 32'(ringing), 32'b00);

`ifdef ALARM_SNOOZE_EN
        // Snooze
        load(5, 59, 59);
        ticks(1);
        chk("snz_trig", 32'(ringing), 32'b11);
        snooze = 2'b01;
        ack = 2'b10;
        step();
        snooze = 2'b00;
        ack = 2'b00;
        chk("snoozed", 32'(ringing), 32'b00);
        ticks(299);
        chk("snz_299", 32'(ringing), 32'b00);
        ticks(1);
        chk("snz_rering", 32'(ringing), 32'b01);
        ack = 2'b01;
        step();
        ack = 2'b00;
        chk("snz_ack", 32'(ringing), 32'b00);
`endif

        // Load beats tick
        tick = 1'b1;
        load(10, 0, 0);
        tick = 1'b0;
        chk("load_beats_tick", now(), t(10, 0, 0));

        // Ack beats trigger
        wr_alarm(0, 10, 1, 1'b1);
        load(10, 0, 59);
        tick = 1'b1;
        ack = 2'b01;
        step();
        tick = 1'b0;
        ack = 2'b00;
        chk("ack_beats_trig", 32'(ringing), 32'b00);
        chk("ack_trig_time", now(), t(10, 1, 0));

        // Disarm and reset during ringing
        wr_alarm(0, 10, 2, 1'b1);
        wr_alarm(1, 10, 2, 1'b1);
        load(10, 1, 59);
        ticks(1);
        chk("both_ring", 32'(ringing), 32'b11);
        wr_alarm(0, 10, 2, 1'b0);
        chk("disarm", 32'(ringing), 32'b10);
        rst = 1'b1;
        tick = 1'b1;
        step();
        rst = 1'b0;
        tick = 1'b0;
        chk("rst_ring", 32'(ringing), 32'b00);
        chk("rst_time", now(), t(0, 0, 0));
        chk("rst_roll", 32'(rollover), 32'd0);
        chk("rst_err", 32'(set_err), 32'd0);
        load(23, 59, 59);
        ticks(1);
        chk("post_rst_roll", 32'(rollover), 32'd1);
        chk("post_rst_noring", 32'(ringing), 32'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
